// File: rtl/posted_write_buffer.sv
// Posted-write buffer between the cache memory port and data memory: writes complete in one
// cycle into a FIFO and drain in order; reads wait for drain. Optional macro WB_FORWARD_EN.
module posted_write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] up_addr_i,
   input  logic [31:0] up_wdata_i,
   input  logic        up_we_i,
   input  logic [3:0]  up_be_i,
   input  logic        up_req_i,
   output logic        up_gnt_o,
   output logic        up_rvalid_o,
   output logic [31:0] up_rdata_o,
   output logic        up_error_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic        mem_req_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic        mem_error_i,
   output logic        wb_empty_o,
   output logic        wb_error_o,
   output logic [2:0]  dbg_state_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      M_IDLE  = 3'd0,
      M_WREQ  = 3'd1,
      M_WWAIT = 3'd2,
      M_RREQ  = 3'd3,
      M_RWAIT = 3'd4
   } mstate_t;

   mstate_t r_state;
   mstate_t w_state_nxt;

   logic [31:0]   r_fifo_addr [DEPTH];
   logic [31:0]   r_fifo_data [DEPTH];
   logic [3:0]    r_fifo_be   [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [AW:0]   w_count_nxt;

   logic          r_up_rvalid;
   logic [31:0]   r_up_rdata;
   logic          r_up_error;
   logic          r_wb_error;
   logic [31:0]   r_rd_addr;
   logic [3:0]    r_rd_be;

   logic          w_full;
   logic          w_empty;
   logic          w_wb_empty;
   logic          w_resp_pending;
   logic          w_wr_gnt;
   logic          w_rd_mem_gnt;
   logic          w_rd_fwd_gnt;
   logic [31:0]   w_fwd_data;
   logic          w_push;
   logic          w_pop;

   // Handshake: up_req_i is held until up_gnt_o; a granted request always gets exactly one
   // up_rvalid_o pulse later, and no new grant is issued until that pulse has been sent.
   assign w_full         = (r_count == FULL_CNT);
   assign w_empty        = (r_count == '0);
   assign w_wb_empty     = w_empty & (r_state == M_IDLE);
   assign w_resp_pending = r_up_rvalid | (r_state == M_RREQ) | (r_state == M_RWAIT);

   assign w_wr_gnt     = up_req_i & up_we_i & ~w_full & ~w_resp_pending;
   assign w_rd_mem_gnt = up_req_i & ~up_we_i & w_wb_empty & ~w_resp_pending;

`ifdef WB_FORWARD_EN
   logic          w_fwd_full;
   logic [AW-1:0] w_fwd_idx;

   // Walk oldest to youngest so the youngest matching entry decides the outcome.
   always_comb begin
      w_fwd_full = 1'b0;
      w_fwd_data = '0;
      w_fwd_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_fwd_idx = r_rd_ptr + AW'(i);
         if (((AW+1)'(i) < r_count) &&
             (r_fifo_addr[w_fwd_idx][31:2] == up_addr_i[31:2])) begin
            w_fwd_full = &r_fifo_be[w_fwd_idx];
            w_fwd_data = r_fifo_data[w_fwd_idx];
         end
      end
   end

   assign w_rd_fwd_gnt = up_req_i & ~up_we_i & ~w_empty & ~w_resp_pending & w_fwd_full;
`else
   assign w_rd_fwd_gnt = 1'b0;
   assign w_fwd_data   = '0;
`endif

   assign up_gnt_o = w_wr_gnt | w_rd_mem_gnt | w_rd_fwd_gnt;
   assign w_push   = w_wr_gnt;
   assign w_pop    = (r_state == M_WWAIT) & mem_rvalid_i;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // A write granted while idle starts the drain straight away, so mem_req_o rises the next cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         M_IDLE: begin
            if (!w_empty || w_push)
               w_state_nxt = M_WREQ;
            else if (w_rd_mem_gnt)
               w_state_nxt = M_RREQ;
         end
         M_WREQ: begin
            if (mem_gnt_i)
               w_state_nxt = M_WWAIT;
         end
         M_WWAIT: begin
            if (mem_rvalid_i)
               w_state_nxt = (w_count_nxt != '0) ? M_WREQ : M_IDLE;
         end
         M_RREQ: begin
            if (mem_gnt_i)
               w_state_nxt = M_RWAIT;
         end
         M_RWAIT: begin
            if (mem_rvalid_i)
               w_state_nxt = M_IDLE;
         end
         default: w_state_nxt = M_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= M_IDLE;
         r_count     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_up_rvalid <= 1'b0;
         r_up_rdata  <= '0;
         r_up_error  <= 1'b0;
         r_wb_error  <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_be     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_up_rvalid <= 1'b0;
         r_up_rdata  <= '0;
         r_up_error  <= 1'b0;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr_gnt) begin
            r_up_rvalid <= 1'b1;
         end else if (w_rd_fwd_gnt) begin
            r_up_rvalid <= 1'b1;
            r_up_rdata  <= w_fwd_data;
         end else if ((r_state == M_RWAIT) && mem_rvalid_i) begin
            r_up_rvalid <= 1'b1;
            r_up_rdata  <= mem_rdata_i;
            r_up_error  <= mem_error_i;
         end
         if (w_rd_mem_gnt) begin
            r_rd_addr <= up_addr_i;
            r_rd_be   <= up_be_i;
         end
         if (w_pop && mem_error_i)
            r_wb_error <= 1'b1;
      end
   end

   // Entry storage needs no reset: the count and pointers define which slots are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= up_addr_i;
         r_fifo_data[r_wr_ptr] <= up_wdata_i;
         r_fifo_be[r_wr_ptr]   <= up_be_i;
      end
   end

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (r_state == M_WREQ) begin
         mem_req_o   = 1'b1;
         mem_we_o    = 1'b1;
         mem_addr_o  = r_fifo_addr[r_rd_ptr];
         mem_wdata_o = r_fifo_data[r_rd_ptr];
         mem_be_o    = r_fifo_be[r_rd_ptr];
      end else if (r_state == M_RREQ) begin
         mem_req_o  = 1'b1;
         mem_addr_o = r_rd_addr;
         mem_be_o   = r_rd_be;
      end
   end

   assign up_rvalid_o = r_up_rvalid;
   assign up_rdata_o  = r_up_rdata;
   assign up_error_o  = r_up_error;
   assign wb_empty_o  = w_wb_empty;
   assign wb_error_o  = r_wb_error;
   assign dbg_state_o = r_state;

endmodule
